// File: rtl/pwm_timer_pkg.sv
// Shared register map and bit positions for the PWM timer peripheral.
package pwm_timer_pkg;

  // Word index = addr[4:2]
  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PERIOD = 3'd1,
    REG_DUTY   = 3'd2,
    REG_PRESC  = 3'd3,
    REG_STATUS = 3'd4,
    REG_COUNT  = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_INV_BIT    = 1;
  localparam int unsigned STATUS_DONE_BIT = 0;

endpackage

// File: rtl/pwm_timer_prescaler.sv
// Prescaler for the PWM timer: emits one tick every (presc+1) enabled cycles.
module pwm_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  // Tick at the terminal count; >= guards against PRESC being lowered below the running count.
  always_comb begin
    tick   = en && (pcnt_q >= presc);
    pcnt_d = pcnt_q;
    if (!en || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  // Prescaler counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// Memory-mapped PWM timer: staging registers, double-buffered period/duty,
// prescaled up-counter, registered compare output and period-end pulse.
module pwm_timer
  import pwm_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [4:0]  addr,
  input  logic [31:0] data_in,
  input  logic        write_en,
  output logic [31:0] data_out,
  output logic        pwm_out,
  output logic        period_irq
);

  logic               en_q, en_d;
  logic               inv_q, inv_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   per_sh_q, per_sh_d;
  logic [CNT_W-1:0]   duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pwm_q, pwm_d;
  logic               irq_q, irq_d;

  logic               tick;
  logic               boundary;
  logic               wr;
  reg_idx_e           ridx;
  logic               unused_bits;

  assign ridx        = reg_idx_e'(addr[4:2]);
  assign unused_bits = ^{addr[1:0], data_in[31:CNT_W]};

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (en_q),
    .presc (presc_q),
    .tick  (tick)
  );

  // Register file writes; a DONE set on a boundary overrides a simultaneous clear
  always_comb begin
    en_d     = en_q;
    inv_d    = inv_q;
    period_d = period_q;
    duty_d   = duty_q;
    presc_d  = presc_q;
    done_d   = done_q;
    wr       = sel && write_en;
    if (wr) begin
      case (ridx)
        REG_CTRL: begin
          en_d  = data_in[CTRL_EN_BIT];
          inv_d = data_in[CTRL_INV_BIT];
        end
        REG_PERIOD: period_d = data_in[CNT_W-1:0];
        REG_DUTY:   duty_d   = data_in[CNT_W-1:0];
        REG_PRESC:  presc_d  = data_in[PRESC_W-1:0];
        REG_STATUS: if (data_in[STATUS_DONE_BIT]) done_d = 1'b0;
        default: ;
      endcase
    end
    if (boundary) begin
      done_d = 1'b1;
    end
  end

  // Main counter, shadow reload at period end, compare output and irq
  always_comb begin
    boundary  = tick && (cnt_q == per_sh_q);
    cnt_d     = cnt_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    if (!en_q || boundary) begin
      // Shadows follow staging while idle and reload from the pre-write value at a boundary
      cnt_d     = '0;
      per_sh_d  = period_q;
      duty_sh_d = duty_q;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    irq_d = boundary;
    pwm_d = en_q ? ((cnt_q < duty_sh_q) ^ inv_q) : inv_q;
  end

  // Readback mux; unused bits and reserved words read 0
  always_comb begin
    data_out = '0;
    case (ridx)
      REG_CTRL: begin
        data_out[CTRL_EN_BIT]  = en_q;
        data_out[CTRL_INV_BIT] = inv_q;
      end
      REG_PERIOD: data_out = 32'(period_q);
      REG_DUTY:   data_out = 32'(duty_q);
      REG_PRESC:  data_out = 32'(presc_q);
      REG_STATUS: data_out[STATUS_DONE_BIT] = done_q;
      REG_COUNT:  data_out = 32'(cnt_q);
      default:    data_out = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      inv_q     <= 1'b0;
      period_q  <= '0;
      duty_q    <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      cnt_q     <= '0;
      pwm_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      inv_q     <= inv_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_irq = irq_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboard bench for pwm_timer: expected waveform entries are queued when a
// run is started and popped on each falling edge against the DUT outputs.
module tb_pwm_timer;
  import pwm_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        write_en;
  logic [31:0] data_out;
  logic        pwm_out;
  logic        period_irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic        pwm;
    logic        irq;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pwm_timer #(
    .CNT_W   (16),
    .PRESC_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .addr       (addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .data_out   (data_out),
    .pwm_out    (pwm_out),
    .period_irq (period_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge; the write lands on the following rising edge.
  task automatic wr_reg(input int unsigned idx, input logic [31:0] d);
    sel      = 1'b1;
    write_en = 1'b1;
    addr     = 5'(idx * 4);
    data_in  = d;
    @(negedge clk);
    sel      = 1'b0;
    write_en = 1'b0;
    data_in  = '0;
  endtask

  task automatic rd_reg(input int unsigned idx, output logic [31:0] d);
    addr = 5'(idx * 4);
    #1;
    d = data_out;
  endtask

  // PERIOD=9 throughout. Cycle k counts falling edges after the enabling write edge.
  // Duty d0 applies to the first period, d1 afterwards; p = PRESC+1.
  // An optional write (wr_k > 0) is driven during cycle wr_k.
  task automatic run_cycles(input int n, input int p, input int d0, input int d1,
                            input bit inv, input int wr_k,
                            input int unsigned wr_idx, input logic [31:0] wr_data);
    exp_t e;
    int   duty;
    for (int k = 1; k <= n; k++) begin
      duty  = (((k - 1) / (10 * p)) == 0) ? d0 : d1;
      e.pwm = ((((k - 1) / p) % 10) < duty) ^ inv;
      e.irq = ((k % (10 * p)) == 0);
      e.cnt = 32'((k / p) % 10);
      sb.push_back(e);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      sel      = 1'b0;
      write_en = 1'b0;
      addr     = 5'(REG_COUNT * 4);
      #1;
      e = sb.pop_front();
      check_eq("pwm_out", 32'(pwm_out), 32'(e.pwm));
      check_eq("period_irq", 32'(period_irq), 32'(e.irq));
      check_eq("count", data_out, e.cnt);
      if (k == wr_k) begin
        sel      = 1'b1;
        write_en = 1'b1;
        addr     = 5'(wr_idx * 4);
        data_in  = wr_data;
      end
    end
    sel      = 1'b0;
    write_en = 1'b0;
    data_in  = '0;
  endtask

  initial begin
    logic [31:0] rd;
    rst      = 1'b0;
    sel      = 1'b0;
    write_en = 1'b0;
    addr     = '0;
    data_in  = '0;

    // Reset state
    #12;
    check_eq("rst_pwm", 32'(pwm_out), 32'd0);
    check_eq("rst_irq", 32'(period_irq), 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      rd_reg(i, rd);
      check_eq("rst_reg", rd, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // PERIOD=9 DUTY=3 PRESC=0: 3 high / 7 low, irq every 10 cycles
    wr_reg(REG_PERIOD, 32'hABCD_0009);
    rd_reg(REG_PERIOD, rd);
    check_eq("period_trunc", rd, 32'd9);
    wr_reg(REG_DUTY, 32'd3);
    wr_reg(REG_PRESC, 32'd0);
    wr_reg(REG_RSVD6, 32'hFFFF_FFFF);
    rd_reg(REG_RSVD6, rd);
    check_eq("rsvd6", rd, 32'd0);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(30, 1, 3, 3, 1'b0, 0, 0, 32'd0);
    rd_reg(REG_STATUS, rd);
    check_eq("done_set", rd, 32'd1);
    rd_reg(REG_CTRL, rd);
    check_eq("ctrl_rd", rd, 32'd1);

    // Write-1-to-clear DONE away from a boundary
    wr_reg(REG_STATUS, 32'd1);
    rd_reg(REG_STATUS, rd);
    check_eq("done_clr", rd, 32'd0);

    // PRESC=1: 6 high / 14 low, COUNT steps every 2 cycles
    wr_reg(REG_CTRL, 32'd0);
    wr_reg(REG_PRESC, 32'd1);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(60, 2, 3, 3, 1'b0, 0, 0, 32'd0);

    // DUTY=7 written at cnt=4: current period keeps 3, next is 7 high / 3 low
    wr_reg(REG_CTRL, 32'd0);
    wr_reg(REG_PRESC, 32'd0);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(30, 1, 3, 7, 1'b0, 4, REG_DUTY, 32'd7);
    rd_reg(REG_DUTY, rd);
    check_eq("duty_rd", rd, 32'd7);

    // DUTY=0 -> constant 0
    wr_reg(REG_CTRL, 32'd0);
    wr_reg(REG_DUTY, 32'd0);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(20, 1, 0, 0, 1'b0, 0, 0, 32'd0);

    // DUTY=20 > PERIOD -> constant 1
    wr_reg(REG_CTRL, 32'd0);
    wr_reg(REG_DUTY, 32'd20);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(20, 1, 20, 20, 1'b0, 0, 0, 32'd0);

    // Idle level with INV=1, then inverted constants
    wr_reg(REG_CTRL, 32'd2);
    @(negedge clk);
    #1;
    check_eq("idle_inv", 32'(pwm_out), 32'd1);
    wr_reg(REG_CTRL, 32'd3);
    run_cycles(20, 1, 20, 20, 1'b1, 0, 0, 32'd0);
    wr_reg(REG_CTRL, 32'd2);
    wr_reg(REG_DUTY, 32'd0);
    wr_reg(REG_CTRL, 32'd3);
    run_cycles(20, 1, 0, 0, 1'b1, 0, 0, 32'd0);

    // STATUS clear coinciding with the boundary: set wins
    wr_reg(REG_CTRL, 32'd0);
    wr_reg(REG_STATUS, 32'd1);
    rd_reg(REG_STATUS, rd);
    check_eq("done_clr2", rd, 32'd0);
    wr_reg(REG_DUTY, 32'd3);
    wr_reg(REG_CTRL, 32'd1);
    run_cycles(10, 1, 3, 3, 1'b0, 9, REG_STATUS, 32'd1);
    rd_reg(REG_STATUS, rd);
    check_eq("done_set_wins", rd, 32'd1);

    // Write strobe without select is ignored
    sel      = 1'b0;
    write_en = 1'b1;
    addr     = 5'(REG_PERIOD * 4);
    data_in  = 32'd5;
    @(negedge clk);
    write_en = 1'b0;
    rd_reg(REG_PERIOD, rd);
    check_eq("nosel_ignored", rd, 32'd9);

    // Asynchronous reset mid-period with INV set
    wr_reg(REG_CTRL, 32'd3);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_pwm", 32'(pwm_out), 32'd0);
    check_eq("mid_rst_irq", 32'(period_irq), 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      rd_reg(i, rd);
      check_eq("mid_rst_reg", rd, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
